// File: rtl/err_monitor_if.sv
// Commit/error signal bundle between the retirement stage and err_monitor.
// The slave modport is the monitor's view; the master drives commits and error strobes.
interface err_monitor_if #(
  parameter int CNT_W = 32
);
  logic             commit_valid;
  logic             halt;
  logic             mem_err;
  logic             illegal_instr;
  logic             err;
  logic [1:0]       err_code;
  logic             done;
  logic [1:0]       state;
  logic [CNT_W-1:0] commit_count;

  modport master (
    output commit_valid, halt, mem_err, illegal_instr,
    input  err, err_code, done, state, commit_count
  );

  modport slave (
    input  commit_valid, halt, mem_err, illegal_instr,
    output err, err_code, done, state, commit_count
  );
endinterface

// File: rtl/err_monitor.sv
// Program-execution monitor: counts retired instructions and latches a clean halt or the first error cause.
// Optional watchdog on commit-free cycles is enabled with `define ERR_MONITOR_WATCHDOG_EN.
module err_monitor #(
  parameter int TIMEOUT = 1000,
  parameter int CNT_W   = 32
) (
  input logic          clk,
  input logic          rst,
  err_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       code_q, code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wdt_fire_s;

`ifdef ERR_MONITOR_WATCHDOG_EN
  logic [15:0] wdt_q, wdt_d;

  // Fires on the TIMEOUT-th consecutive commit-free RUN cycle; a commit that cycle rescues it.
  assign wdt_fire_s = (wdt_q == 16'(TIMEOUT - 1)) && !bus.commit_valid;
`else
  assign wdt_fire_s = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
`ifdef ERR_MONITOR_WATCHDOG_EN
    wdt_d   = wdt_q;
`endif
    case (state_q)
      IDLE: begin
        state_d = RUN;
      end
      RUN: begin
        if (bus.commit_valid && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
`ifdef ERR_MONITOR_WATCHDOG_EN
        if (bus.commit_valid) begin
          wdt_d = 16'd0;
        end else begin
          wdt_d = wdt_q + 16'd1;
        end
`endif
        // Error inputs outrank a simultaneous halt, so a faulting HALT never reports done.
        if (bus.mem_err) begin
          state_d = FAULT;
          code_d  = 2'd1;
        end else if (bus.illegal_instr) begin
          state_d = FAULT;
          code_d  = 2'd2;
        end else if (bus.commit_valid && bus.halt) begin
          state_d = DONE;
        end else if (wdt_fire_s) begin
          state_d = FAULT;
          code_d  = 2'd3;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      code_q  <= 2'd0;
      cnt_q   <= '0;
`ifdef ERR_MONITOR_WATCHDOG_EN
      wdt_q   <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
`ifdef ERR_MONITOR_WATCHDOG_EN
      wdt_q   <= wdt_d;
`endif
    end
  end

  assign bus.state        = state_q;
  assign bus.err          = (state_q == FAULT);
  assign bus.done         = (state_q == DONE);
  assign bus.err_code     = code_q;
  assign bus.commit_count = cnt_q;

endmodule

// File: tb/tb_err_monitor.sv
// Directed bench for err_monitor (CNT_W=4, TIMEOUT=8); watchdog expectations follow ERR_MONITOR_WATCHDOG_EN.
module tb_err_monitor;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  err_monitor_if #(.CNT_W(4)) bus ();

  err_monitor #(
    .TIMEOUT (8),
    .CNT_W   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Apply inputs, let one rising edge sample them, return 1 time unit after that edge.
  task automatic step(input logic cv, input logic h, input logic me, input logic ii);
    bus.commit_valid  = cv;
    bus.halt          = h;
    bus.mem_err       = me;
    bus.illegal_instr = ii;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2;
    rst               = 1'b0;
    bus.commit_valid  = 1'b0;
    bus.halt          = 1'b0;
    bus.mem_err       = 1'b0;
    bus.illegal_instr = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst               = 1'b0;
    bus.commit_valid  = 1'b1;
    bus.halt          = 1'b1;
    bus.mem_err       = 1'b0;
    bus.illegal_instr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_code", 32'(bus.err_code), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_count", 32'(bus.commit_count), 32'd0);

    // Clean run: 5 commits then a counted HALT
    do_reset();
    check("run_after_release", 32'(bus.state), 32'd1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("count5", 32'(bus.commit_count), 32'd5);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("halt_state", 32'(bus.state), 32'd2);
    check("halt_done", 32'(bus.done), 32'd1);
    check("halt_count", 32'(bus.commit_count), 32'd6);
    check("halt_err", 32'(bus.err), 32'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("done_absorb_state", 32'(bus.state), 32'd2);
    check("done_absorb_count", 32'(bus.commit_count), 32'd6);
    check("done_absorb_err", 32'(bus.err), 32'd0);

    // Simultaneous mem_err and illegal_instr: mem_err wins
    do_reset();
    check("fresh_count", 32'(bus.commit_count), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("both_state", 32'(bus.state), 32'd3);
    check("both_err", 32'(bus.err), 32'd1);
    check("both_code", 32'(bus.err_code), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("fault_frozen_count", 32'(bus.commit_count), 32'd0);
    check("fault_frozen_code", 32'(bus.err_code), 32'd1);

    // halt without commit ignored; halt+commit+illegal faults but counts
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("bare_halt_state", 32'(bus.state), 32'd1);
    check("bare_halt_done", 32'(bus.done), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("halt_ill_state", 32'(bus.state), 32'd3);
    check("halt_ill_code", 32'(bus.err_code), 32'd2);
    check("halt_ill_done", 32'(bus.done), 32'd0);
    check("halt_ill_count", 32'(bus.commit_count), 32'd3);

    // Watchdog boundary: 7 idle + commit survives, then 8 idle cycles
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("wdt_7idle_state", 32'(bus.state), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("wdt_rescue_state", 32'(bus.state), 32'd1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("wdt_pre_fire_state", 32'(bus.state), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ERR_MONITOR_WATCHDOG_EN
    check("wdt_fire_state", 32'(bus.state), 32'd3);
    check("wdt_fire_code", 32'(bus.err_code), 32'd3);
    check("wdt_fire_err", 32'(bus.err), 32'd1);
`else
    check("nowdt_state", 32'(bus.state), 32'd1);
    check("nowdt_err", 32'(bus.err), 32'd0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("nowdt_long_state", 32'(bus.state), 32'd1);
    check("nowdt_long_code", 32'(bus.err_code), 32'd0);
`endif

    // Asynchronous reset from FAULT between clock edges
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("pre_arst_state", 32'(bus.state), 32'd3);
    check("pre_arst_count", 32'(bus.commit_count), 32'd3);
    #2;
    rst = 1'b0;
    #1;
    check("arst_state", 32'(bus.state), 32'd0);
    check("arst_err", 32'(bus.err), 32'd0);
    check("arst_code", 32'(bus.err_code), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_count", 32'(bus.commit_count), 32'd0);
    bus.mem_err = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("release_idle", 32'(bus.state), 32'd0);
    @(posedge clk);
    #1;
    check("release_run", 32'(bus.state), 32'd1);

    // Saturation at 15 for CNT_W=4
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("sat_14", 32'(bus.commit_count), 32'd14);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("sat_15", 32'(bus.commit_count), 32'd15);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("sat_hold1", 32'(bus.commit_count), 32'd15);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("sat_hold2", 32'(bus.commit_count), 32'd15);
    check("sat_state", 32'(bus.state), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
